pipe_stage_regs: RTL
====================

// Module: pipe_stage_regs
// PURPOSE
//  Front-end pipeline register set (PC, IF/ID, ID/EX) of the RV32I core; the consumer of StallF/StallD/FlushD/FlushE.
//  Holds or advances the PC and the IF/ID and ID/EX registers each cycle, and inserts NOP bubbles where flushed.
//  Sits between fetch, decode and execute; its E-stage Rs1E/Rs2E/RdE and CtrlE outputs feed hazard detection back.
//  Optional stall/flush performance counters.
// PARAMETERS
//  XLEN       32            datapath width
//  CTRL_W     12            decode control-word width; bit 0 = RegWrite, bit 1 = MemWrite
//  RESET_PC   32'h00000000  PC value loaded on reset
//  NOP_INSTR  32'h00000013  bubble instruction (addi x0,x0,0)
//  CNT_W      16            perf counter width (STAGE_PERF_EN only)
// PORTS
//  clk       in   1          core clock, all state on rising edge
//  rst_n     in   1          asynchronous active-low reset
//  StallF    in   1          hold PC
//  StallD    in   1          hold IF/ID
//  FlushD    in   1          bubble IF/ID
//  FlushE    in   1          bubble ID/EX
//  PCNextF   in   XLEN       next PC from the PC mux
//  InstrF    in   32         instruction-memory read data for PCF
//  CtrlD     in   CTRL_W     decoded control word
//  RegsD     in   15         {Rs1D,Rs2D,RdD}
//  PayloadD  in   3*XLEN     {RD1D,RD2D,ImmExtD}
//  PCF       out  XLEN       fetch PC
//  InstrD    out  32         decode-stage instruction
//  PCD       out  XLEN       decode-stage PC
//  ValidD    out  1          IF/ID holds a real instruction
//  CtrlE     out  CTRL_W     execute control word
//  RegsE     out  15         {Rs1E,Rs2E,RdE}
//  PayloadE  out  3*XLEN     {RD1E,RD2E,ImmExtE}
//  PCE       out  XLEN       execute-stage PC
//  ValidE    out  1          ID/EX holds a real instruction
//  StallCnt  out  CNT_W      cycles with StallD=1 (STAGE_PERF_EN only)
//  FlushCnt  out  CNT_W      cycles with FlushE=1 (STAGE_PERF_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0, async, takes effect immediately):
//    - PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, ValidD=0.
//    - CtrlE=0, RegsE=0, PayloadE=0, PCE=0, ValidE=0, counters=0.
//  - First edge after rst_n rises: PCF<=PCNextF (unless StallF); pipeline fills from there, ValidD=1 one cycle later.
//  - PC register, per edge:
//    - StallF=1: hold.
//    - else PCF<=PCNextF.
//  - IF/ID register, per edge, priority FlushD > StallD > load:
//    - FlushD: InstrD<=NOP_INSTR, PCD<=0, ValidD<=0.
//    - StallD: hold all fields.
//    - load: InstrD<=InstrF, PCD<=PCF, ValidD<=1.
//  - ID/EX register, per edge:
//    - FlushE: CtrlE<=0, RegsE<=0, PayloadE<=0, PCE<=0, ValidE<=0. Bubble has RegWrite=MemWrite=0 and Rd=x0.
//    - else load *D fields, PCE<=PCD, ValidE<=ValidD.
//    - ID/EX is never stalled; a lw stall (StallD & FlushE) repeats D while E takes a bubble.
//  - Simultaneous events:
//    - FlushD & StallD (taken branch during load-use): flush wins, no hold.
//    - StallF without StallD is legal; PC holds, IF/ID loads InstrF again.
//  - Latency: one cycle per stage; no combinational path from any input to any output.
//  - A reset mid-stall or mid-flush discards all in-flight state.
// CONFIGURATION
//  - STAGE_PERF_EN defined: StallCnt/FlushCnt ports exist.
//    - Each increments by 1 on any edge where StallD / FlushE is 1.
//    - Saturates at all-ones; reset to 0.
//  - STAGE_PERF_EN undefined: the ports and counters are absent; other behaviour is identical.
// TESTING
//  - Reset with RESET_PC=32'h100, then 3 free cycles with PCNextF=PCF+4:
//    PCF=0x10C, InstrD=InstrF@0x108, ValidD=1, PCE=0x104.
//  - Load-use (StallF=StallD=FlushE=1 for 1 cycle):
//    PCF and InstrD hold, ValidE=0, CtrlE=0, then resume with no lost instruction.
//  - Taken branch (FlushD=FlushE=1 for 1 cycle):
//    InstrD=0x00000013, ValidD=0, ValidE=0, PCF=PCNextF target.
//  - FlushD=StallD=1 together: IF/ID is bubbled, not held.
//  - Assert rst_n low mid-stall between clock edges:
//    outputs take their reset values immediately, not at the next edge.
//  - STAGE_PERF_EN with CNT_W=4 and 20 stall cycles: StallCnt=4'hF, stays saturated.

Source files
------------

// File: rtl/pipe_stage_regs_if.sv
// Bus between fetch/decode/hazard logic and the PC, IF/ID and ID/EX pipeline registers.
// The slave modport is the register set; the master modport is the surrounding core.
interface pipe_stage_regs_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 12
);
    logic                StallF;
    logic                StallD;
    logic                FlushD;
    logic                FlushE;
    logic [XLEN-1:0]     PCNextF;
    logic [31:0]         InstrF;
    logic [CTRL_W-1:0]   CtrlD;
    logic [14:0]         RegsD;
    logic [3*XLEN-1:0]   PayloadD;

    logic [XLEN-1:0]     PCF;
    logic [31:0]         InstrD;
    logic [XLEN-1:0]     PCD;
    logic                ValidD;
    logic [CTRL_W-1:0]   CtrlE;
    logic [14:0]         RegsE;
    logic [3*XLEN-1:0]   PayloadE;
    logic [XLEN-1:0]     PCE;
    logic                ValidE;

    modport slave (
        input  StallF, StallD, FlushD, FlushE, PCNextF, InstrF, CtrlD, RegsD, PayloadD,
        output PCF, InstrD, PCD, ValidD, CtrlE, RegsE, PayloadE, PCE, ValidE
    );

    modport master (
        output StallF, StallD, FlushD, FlushE, PCNextF, InstrF, CtrlD, RegsD, PayloadD,
        input  PCF, InstrD, PCD, ValidD, CtrlE, RegsE, PayloadE, PCE, ValidE
    );
endinterface

// File: rtl/pipe_stage_regs.sv
// PC, IF/ID and ID/EX pipeline registers of the RV32I front end, with stall hold and flush bubbles.
// Define STAGE_PERF_EN to add the saturating StallCnt/FlushCnt performance counters.
module pipe_stage_regs #(
    parameter int              XLEN      = 32,
    parameter int              CTRL_W    = 12,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013,
    parameter int              CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_stage_regs_if.slave     bus
`ifdef STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]     StallCnt,
    output logic [CNT_W-1:0]     FlushCnt
`endif
);

    logic [XLEN-1:0]     pc_f;
    logic [31:0]         instr_d;
    logic [XLEN-1:0]     pc_d;
    logic                valid_d;
    logic [CTRL_W-1:0]   ctrl_e;
    logic [14:0]         regs_e;
    logic [3*XLEN-1:0]   payload_e;
    logic [XLEN-1:0]     pc_e;
    logic                valid_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f <= RESET_PC;
        end else if (!bus.StallF) begin
            pc_f <= bus.PCNextF;
        end
    end

    // Flush outranks stall: a taken branch during a load-use stall must still kill the fetched op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_d <= NOP_INSTR;
            pc_d    <= '0;
            valid_d <= 1'b0;
        end else if (bus.FlushD) begin
            instr_d <= NOP_INSTR;
            pc_d    <= '0;
            valid_d <= 1'b0;
        end else if (!bus.StallD) begin
            instr_d <= bus.InstrF;
            pc_d    <= pc_f;
            valid_d <= 1'b1;
        end
    end

    // ID/EX has no hold; a zeroed control word gives RegWrite=MemWrite=0 and Rd=x0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_e    <= '0;
            regs_e    <= '0;
            payload_e <= '0;
            pc_e      <= '0;
            valid_e   <= 1'b0;
        end else if (bus.FlushE) begin
            ctrl_e    <= '0;
            regs_e    <= '0;
            payload_e <= '0;
            pc_e      <= '0;
            valid_e   <= 1'b0;
        end else begin
            ctrl_e    <= bus.CtrlD;
            regs_e    <= bus.RegsD;
            payload_e <= bus.PayloadD;
            pc_e      <= pc_d;
            valid_e   <= valid_d;
        end
    end

`ifdef STAGE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (bus.StallD && (StallCnt != {CNT_W{1'b1}})) begin
                StallCnt <= StallCnt + CNT_W'(1);
            end
            if (bus.FlushE && (FlushCnt != {CNT_W{1'b1}})) begin
                FlushCnt <= FlushCnt + CNT_W'(1);
            end
        end
    end
`endif

    assign bus.PCF      = pc_f;
    assign bus.InstrD   = instr_d;
    assign bus.PCD      = pc_d;
    assign bus.ValidD   = valid_d;
    assign bus.CtrlE    = ctrl_e;
    assign bus.RegsE    = regs_e;
    assign bus.PayloadE = payload_e;
    assign bus.PCE      = pc_e;
    assign bus.ValidE   = valid_e;

endmodule
